// File: rtl/mc6809_clk_pkg.sv
// Shared phase encoding, E/Q decode and parameter limits for the 6809 clock generator.
// Optional cycle counter in the top is enabled by MC6809_CLKGEN_CYCLE_CNT_EN.
package mc6809_clk_pkg;

  typedef enum logic [1:0] {
    PH_EL_QL = 2'd0,
    PH_EL_QH = 2'd1,
    PH_EH_QH = 2'd2,
    PH_EH_QL = 2'd3
  } phase_e;

  localparam int DIV_MIN         = 1;
  localparam int DIV_MAX         = 256;
  localparam int STRETCH_MIN     = 0;
  localparam int STRETCH_MAX_LIM = 255;

  typedef struct packed {
    logic e;
    logic q;
  } eq_t;

  // Gray-style quadrature: Q leads E by one quarter.
  function automatic eq_t eq_decode(input logic [1:0] ph);
    eq_t r;
    r.e = ph[1];
    r.q = ph[1] ^ ph[0];
    return r;
  endfunction

endpackage

// File: rtl/mc6809_clk_prescale.sv
// Quarter-phase prescaler: qcnt runs 0..DIV-1, tick marks the last count.
// hold forces the count back to zero so a parked bus restarts on a clean quarter.
module mc6809_clk_prescale
  import mc6809_clk_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int            QW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

  logic [QW-1:0] qcnt_q, qcnt_d;

  assign tick = (qcnt_q == QMAX);

  always_comb begin
    qcnt_d = qcnt_q + 1'b1;
    if (hold || tick) qcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) qcnt_q <= '0;
    else       qcnt_q <= qcnt_d;
  end

endmodule

// File: rtl/mc6809_clkgen.sv
// 6809 E/Q quadrature generator with MRDY stretch, RUN parking and edge-enable strobes.
// Define MC6809_CLKGEN_CYCLE_CNT_EN to build the completed E-cycle counter on CYCLES.
module mc6809_clkgen
  import mc6809_clk_pkg::*;
#(
  parameter int DIV         = 1,
  parameter int STRETCH_MAX = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MRDY,
  input  logic        RUN,
  output logic        E,
  output logic        Q,
  output logic        E_RISE_EN,
  output logic        E_FALL_EN,
  output logic        Q_RISE_EN,
  output logic        Q_FALL_EN,
  output logic [1:0]  PHASE,
  output logic        STRETCHED,
  output logic        STRETCH_TIMEOUT,
  output logic [31:0] CYCLES
);

  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $error("mc6809_clkgen: DIV out of range");
  end
  if (STRETCH_MAX < STRETCH_MIN || STRETCH_MAX > STRETCH_MAX_LIM) begin : g_bad_stretch
    $error("mc6809_clkgen: STRETCH_MAX out of range");
  end

  localparam logic [7:0] SMAX = 8'(STRETCH_MAX);

  phase_e     phase_q, phase_d;
  logic [7:0] scnt_q, scnt_d;
  logic       stretched_q, stretched_d;
  logic       timeout_q, timeout_d;
  logic       e_q, q_q;
  logic       e_rise_q, e_rise_d, e_fall_q, e_fall_d;
  logic       q_rise_q, q_rise_d, q_fall_q, q_fall_d;
  eq_t        eq_d;
  logic       tick;
  logic       hold;

  assign hold = (phase_q == PH_EL_QL) && !RUN;

  mc6809_clk_prescale #(.DIV(DIV)) u_prescale (
    .clk   (CLK),
    .reset (RESET),
    .hold  (hold),
    .tick  (tick)
  );

  always_comb begin
    phase_d     = phase_q;
    scnt_d      = scnt_q;
    stretched_d = stretched_q;
    timeout_d   = 1'b0;
    if (tick) begin
      case (phase_q)
        PH_EL_QL: if (RUN) phase_d = PH_EL_QH;
        PH_EL_QH: phase_d = PH_EH_QH;
        PH_EH_QH: phase_d = PH_EH_QL;
        PH_EH_QL: begin
          if (!MRDY && (scnt_q < SMAX)) begin
            scnt_d      = scnt_q + 8'd1;
            stretched_d = 1'b1;
          end else begin
            phase_d     = PH_EL_QL;
            scnt_d      = '0;
            stretched_d = 1'b0;
            // A zero stretch budget means MRDY is simply ignored, not a timeout.
            timeout_d   = !MRDY && (SMAX != 8'd0);
          end
        end
        default: phase_d = PH_EL_QL;
      endcase
    end
    eq_d     = eq_decode(phase_d);
    e_rise_d = eq_d.e & ~e_q;
    e_fall_d = ~eq_d.e & e_q;
    q_rise_d = eq_d.q & ~q_q;
    q_fall_d = ~eq_d.q & q_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q     <= PH_EL_QL;
      scnt_q      <= '0;
      stretched_q <= 1'b0;
      timeout_q   <= 1'b0;
      e_q         <= 1'b0;
      q_q         <= 1'b0;
      e_rise_q    <= 1'b0;
      e_fall_q    <= 1'b0;
      q_rise_q    <= 1'b0;
      q_fall_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      scnt_q      <= scnt_d;
      stretched_q <= stretched_d;
      timeout_q   <= timeout_d;
      e_q         <= eq_d.e;
      q_q         <= eq_d.q;
      e_rise_q    <= e_rise_d;
      e_fall_q    <= e_fall_d;
      q_rise_q    <= q_rise_d;
      q_fall_q    <= q_fall_d;
    end
  end

  assign E               = e_q;
  assign Q               = q_q;
  assign E_RISE_EN       = e_rise_q;
  assign E_FALL_EN       = e_fall_q;
  assign Q_RISE_EN       = q_rise_q;
  assign Q_FALL_EN       = q_fall_q;
  assign PHASE           = phase_q;
  assign STRETCHED       = stretched_q;
  assign STRETCH_TIMEOUT = timeout_q;

`ifdef MC6809_CLKGEN_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (phase_q == PH_EH_QL && phase_d == PH_EL_QL) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign CYCLES = cycles_q;
`else
  assign CYCLES = '0;
`endif

endmodule

// File: tb/tb_mc6809_clkgen.sv
// Scoreboard bench for mc6809_clkgen: three parameter sets driven by per-edge plans built
// from a timeline model of each E cycle; a monitor pops expected outputs after every edge.
module tb_mc6809_clkgen;

  localparam int NL = 3;
  localparam int DIVS [NL] = '{1, 3, 2};
  localparam int SMS  [NL] = '{10, 0, 3};

  typedef struct packed {
    logic [1:0]  ph;
    logic        e, q, er, ef, qr, qf, st, to;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic rst, run, mrdy;
    exp_t x;
  } plan_t;

  logic clk;
  logic        rst_i [NL];
  logic        run_i [NL];
  logic        mrdy_i[NL];
  logic        e_o   [NL];
  logic        q_o   [NL];
  logic        er_o  [NL];
  logic        ef_o  [NL];
  logic        qr_o  [NL];
  logic        qf_o  [NL];
  logic [1:0]  ph_o  [NL];
  logic        st_o  [NL];
  logic        to_o  [NL];
  logic [31:0] cyc_o [NL];

  plan_t plan_q[NL][$];
  exp_t  sb_q  [NL][$];

  logic        m_e  [NL];
  logic        m_q  [NL];
  logic [1:0]  m_ph [NL];
  logic [31:0] m_cyc[NL];

  int n_total = 0;
  int n_bad   = 0;
  int n_step[NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    mc6809_clkgen #(.DIV(DIVS[g]), .STRETCH_MAX(SMS[g])) u_dut (
      .CLK             (clk),
      .RESET           (rst_i[g]),
      .MRDY            (mrdy_i[g]),
      .RUN             (run_i[g]),
      .E               (e_o[g]),
      .Q               (q_o[g]),
      .E_RISE_EN       (er_o[g]),
      .E_FALL_EN       (ef_o[g]),
      .Q_RISE_EN       (qr_o[g]),
      .Q_FALL_EN       (qf_o[g]),
      .PHASE           (ph_o[g]),
      .STRETCHED       (st_o[g]),
      .STRETCH_TIMEOUT (to_o[g]),
      .CYCLES          (cyc_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One plan entry: stimulus for an edge and the outputs expected right after it.
  task automatic push(input int l, input bit rst, input bit run, input bit mrdy,
                      input logic [1:0] ph, input bit st, input bit to);
    plan_t p;
    bit e, q;
    e = (ph == 2'd2) || (ph == 2'd3);
    q = (ph == 2'd1) || (ph == 2'd2);
    p.rst  = rst;
    p.run  = run;
    p.mrdy = mrdy;
    if (rst) begin
      p.x      = '0;
      m_e[l]   = 1'b0;
      m_q[l]   = 1'b0;
      m_ph[l]  = 2'd0;
      m_cyc[l] = '0;
    end else begin
      if (m_ph[l] == 2'd3 && ph == 2'd0) m_cyc[l] = m_cyc[l] + 32'd1;
      p.x.ph = ph;
      p.x.e  = e;
      p.x.q  = q;
      p.x.er = e && !m_e[l];
      p.x.ef = !e && m_e[l];
      p.x.qr = q && !m_q[l];
      p.x.qf = !q && m_q[l];
      p.x.st = st;
      p.x.to = to;
      m_e[l]  = e;
      m_q[l]  = q;
      m_ph[l] = ph;
    end
`ifdef MC6809_CLKGEN_CYCLE_CNT_EN
    p.x.cyc = m_cyc[l];
`else
    p.x.cyc = '0;
`endif
    plan_q[l].push_back(p);
  endtask

  task automatic gen_reset(input int l);
    push(l, 1'b1, rb(), rb(), 2'd0, 1'b0, 1'b0);
  endtask

  // One E cycle from phase-0 entry: j idle edges with RUN low, then the four quarters.
  // k = MRDY-low samples requested in phase 3; cut stops right after entering phase 2.
  task automatic gen_cycle(input int l, input int j, input int k, input bit cut);
    int d, sm, s;
    bit fin;
    d  = DIVS[l];
    sm = SMS[l];
    repeat (j) push(l, 1'b0, 1'b0, rb(), 2'd0, 1'b0, 1'b0);
    for (int i = 1; i < d; i++) push(l, 1'b0, 1'b1, rb(), 2'd0, 1'b0, 1'b0);
    push(l, 1'b0, 1'b1, rb(), 2'd1, 1'b0, 1'b0);
    for (int i = 1; i < d; i++) push(l, 1'b0, rb(), rb(), 2'd1, 1'b0, 1'b0);
    push(l, 1'b0, rb(), rb(), 2'd2, 1'b0, 1'b0);
    if (cut) return;
    for (int i = 1; i < d; i++) push(l, 1'b0, rb(), rb(), 2'd2, 1'b0, 1'b0);
    push(l, 1'b0, rb(), rb(), 2'd3, 1'b0, 1'b0);
    s = (sm == 0) ? 0 : ((k < sm) ? k : sm);
    for (int m = 1; m <= s; m++) begin
      for (int i = 1; i < d; i++) push(l, 1'b0, rb(), rb(), 2'd3, m > 1, 1'b0);
      push(l, 1'b0, rb(), 1'b0, 2'd3, 1'b1, 1'b0);
    end
    for (int i = 1; i < d; i++) push(l, 1'b0, rb(), rb(), 2'd3, s > 0, 1'b0);
    fin = (sm == 0) ? rb() : (k <= sm);
    push(l, 1'b0, rb(), fin, 2'd0, 1'b0, (sm > 0) && !fin);
  endtask

  function automatic exp_t actual(input int l);
    exp_t a;
    a.ph  = ph_o[l];
    a.e   = e_o[l];
    a.q   = q_o[l];
    a.er  = er_o[l];
    a.ef  = ef_o[l];
    a.qr  = qr_o[l];
    a.qf  = qf_o[l];
    a.st  = st_o[l];
    a.to  = to_o[l];
    a.cyc = cyc_o[l];
    return a;
  endfunction

  // Driver: issue one edge of stimulus per lane and hand its expectation to the scoreboard.
  initial begin
    plan_t p;
    for (int l = 0; l < NL; l++) begin
      rst_i[l]  = 1'b1;
      run_i[l]  = 1'b0;
      mrdy_i[l] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (plan_q[l].size() > 0) begin
          p = plan_q[l].pop_front();
          rst_i[l]  = p.rst;
          run_i[l]  = p.run;
          mrdy_i[l] = p.mrdy;
          sb_q[l].push_back(p.x);
        end
      end
    end
  end

  // Monitor: after every edge compare each lane that has an outstanding expectation.
  initial begin
    exp_t x, a;
    for (int l = 0; l < NL; l++) n_step[l] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
        if (sb_q[l].size() > 0) begin
          x = sb_q[l].pop_front();
          a = actual(l);
          n_total++;
          if (a !== x) begin
            n_bad++;
            $display("FAIL lane%0d step%0d outputs: got ph=%0d e=%b q=%b er=%b ef=%b qr=%b qf=%b st=%b to=%b cyc=%0d want ph=%0d e=%b q=%b er=%b ef=%b qr=%b qf=%b st=%b to=%b cyc=%0d",
                     l, n_step[l], a.ph, a.e, a.q, a.er, a.ef, a.qr, a.qf, a.st, a.to, a.cyc,
                     x.ph, x.e, x.q, x.er, x.ef, x.qr, x.qf, x.st, x.to, x.cyc);
          end
          n_step[l]++;
        end
      end
    end
  end

  initial begin
    bit busy;
    int j, k;
    for (int l = 0; l < NL; l++) begin
      m_e[l] = 1'b0; m_q[l] = 1'b0; m_ph[l] = 2'd0; m_cyc[l] = '0;
      repeat (3) gen_reset(l);
      gen_cycle(l, 0, 0, 1'b0);
      gen_cycle(l, 0, 4, 1'b0);
      gen_cycle(l, 0, 50, 1'b0);
      gen_cycle(l, 0, 0, 1'b0);
      gen_cycle(l, 0, SMS[l], 1'b0);
      gen_cycle(l, 5, 0, 1'b0);
      gen_cycle(l, 0, 0, 1'b1);
      gen_reset(l);
      for (int c = 0; c < 40; c++) begin
        j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
        k = int'($urandom_range(0, SMS[l] + 3));
        gen_cycle(l, j, k, 1'b0);
      end
      gen_reset(l);
      for (int c = 0; c < 100; c++) gen_cycle(l, 0, 0, 1'b0);
      gen_cycle(l, 2, 0, 1'b0);
    end

    busy = 1'b1;
    for (int c = 0; c < 60000 && busy; c++) begin
      @(posedge clk);
      #2;
      busy = 1'b0;
      for (int l = 0; l < NL; l++)
        if (plan_q[l].size() > 0 || sb_q[l].size() > 0) busy = 1'b1;
    end
    if (busy) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: got outstanding entries, want all plans checked within budget");
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
